user_module_341360223723717202_core: RTL and testbench

USER_MODULE_341360223723717202_CORE -- requirements
Module: user_module_341360223723717202

---
 rtl/user_module_341360223723717202_core.sv | 136 +++++++++++++
 tb/tb_user_module_341360223723717202_core.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/user_module_341360223723717202_core.sv
// -----------------------------------------------------------------------------
// user_module_341360223723717202_core
//
// This is a tiny 6-bit accumulator CPU. It fetches instructions from an
// external memory. Every instruction takes two clock cycles:
//   - a fetch phase (micro_pc = 0), and
//   - an execute phase (micro_pc = 1).
//
// The memory is combinational and sits outside the core:
//   - the core presents an address on io_out[5:0];
//   - the memory answers on io_in[7:2] within the same cycle.
// Opcodes that carry an operand (JMP, JZ, LDI) keep pc on the operand word
// during execute, so the operand arrives on io_in[7:2] in that cycle.
//
// Ports:
//   io_in[0]    clock (rising edge)
//   io_in[1]    synchronous active-high reset
//   io_in[7:2]  data word from memory for the address on io_out[5:0]
//   io_out[5:0] address (pc), or reg_a during an OUT execute cycle
//   io_out[6]   phase (micro_pc)
//   io_out[7]   output strobe, high only during an OUT execute cycle
//
// State that can be probed hierarchically:
//   reg_a, reg_b, reg_c, pc, instr (6 bits each) and micro_pc (1 bit).
// -----------------------------------------------------------------------------
module user_module_341360223723717202_core (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_e;

  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SWAP = 6'd2;
  localparam logic [5:0] OP_LDC  = 6'd3;
  localparam logic [5:0] OP_STC  = 6'd4;
  localparam logic [5:0] OP_JMP  = 6'd5;
  localparam logic [5:0] OP_JZ   = 6'd6;
  localparam logic [5:0] OP_LDI  = 6'd7;
  localparam logic [5:0] OP_INC  = 6'd8;
  localparam logic [5:0] OP_NOT  = 6'd9;
  localparam logic [5:0] OP_OUT  = 6'd16;

  logic       clk;
  logic       rst;
  logic [5:0] din;

  assign clk = io_in[0];
  assign rst = io_in[1];
  assign din = io_in[7:2];

  phase_e     micro_pc_q, micro_pc_d;
  logic [5:0] reg_a_q, reg_a_d;
  logic [5:0] reg_b_q, reg_b_d;
  logic [5:0] reg_c_q, reg_c_d;
  logic [5:0] pc_q, pc_d;
  logic [5:0] instr_q, instr_d;

  // Plain names for hierarchical probing; the logic below reads these.
  logic       micro_pc;
  logic [5:0] reg_a, reg_b, reg_c, pc, instr;

  assign micro_pc = micro_pc_q;
  assign reg_a    = reg_a_q;
  assign reg_b    = reg_b_q;
  assign reg_c    = reg_c_q;
  assign pc       = pc_q;
  assign instr    = instr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      micro_pc_q <= PH_FETCH;
      reg_a_q    <= 6'd0;
      reg_b_q    <= 6'd1;
      reg_c_q    <= 6'd0;
      pc_q       <= 6'd0;
      instr_q    <= 6'd0;
    end else begin
      micro_pc_q <= micro_pc_d;
      reg_a_q    <= reg_a_d;
      reg_b_q    <= reg_b_d;
      reg_c_q    <= reg_c_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
    end
  end

  // Next-state logic. Arithmetic is 6 bits wide, so pc + 1 wraps 63 -> 0.
  always_comb begin
    micro_pc_d = PH_FETCH;
    reg_a_d    = reg_a;
    reg_b_d    = reg_b;
    reg_c_d    = reg_c;
    pc_d       = pc;
    instr_d    = instr;

    if (micro_pc == PH_FETCH) begin
      instr_d    = din;
      pc_d       = pc + 6'd1;
      micro_pc_d = PH_EXEC;
    end else begin
      case (instr)
        OP_ADD:  reg_a_d = reg_a + reg_b;
        OP_SWAP: begin
          reg_a_d = reg_b;
          reg_b_d = reg_a;
        end
        OP_LDC:  reg_a_d = reg_c;
        OP_STC:  reg_c_d = reg_a;
        OP_JMP:  pc_d = din;
        // The zero test uses reg_a as it was at the start of the cycle.
        OP_JZ:   pc_d = (reg_a == 6'd0) ? din : pc + 6'd1;
        OP_LDI: begin
          reg_a_d = din;
          pc_d    = pc + 6'd1;
        end
        OP_INC:  reg_a_d = reg_a + 6'd1;
        OP_NOT:  reg_a_d = ~reg_a;
        default: ; // NOP, OUT and unassigned opcodes change no state
      endcase
    end
  end

  // io_out depends only on registered state.
  always_comb begin
    io_out = {2'b00, pc};
    if (micro_pc == PH_EXEC) begin
      if (instr == OP_OUT) io_out = {2'b11, reg_a};
      else                 io_out = {2'b01, pc};
    end
  end

endmodule

// File: tb/tb_user_module_341360223723717202_core.sv
module tb_user_module_341360223723717202_core;

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_seen = 1'b0;   // reset level sampled by the last rising edge
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic [5:0] mem [64];

  always #5 clk = ~clk;

  // Behavioural program memory, answering on whatever address the core drives.
  assign io_in = {mem[io_out[5:0]], rst, clk};

  user_module_341360223723717202_core dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always @(posedge clk) rst_seen <= rst;

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  int out_pulses = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Instruction-level model
  //
  // It runs one whole instruction at a time. For each instruction it queues
  // the two io_out values that instruction must show (the fetch cycle, then
  // the execute cycle), and it updates the architectural registers.
  // ---------------------------------------------------------------------------
  logic [5:0] m_a, m_b, m_c, m_pc;
  logic       m_valid = 1'b0;
  logic [7:0] exp_q[$];

  task automatic iss_step();
    logic [5:0] op, opnd, tmp, next_pc;
    logic [7:0] exec_out;
    op       = mem[m_pc];
    opnd     = mem[m_pc + 6'd1];
    next_pc  = m_pc + 6'd1;
    exec_out = {2'b01, next_pc};
    case (op)
      6'd1:  m_a = m_a + m_b;
      6'd2:  begin tmp = m_a; m_a = m_b; m_b = tmp; end
      6'd3:  m_a = m_c;
      6'd4:  m_c = m_a;
      6'd5:  next_pc = opnd;
      6'd6:  next_pc = (m_a == 6'd0) ? opnd : m_pc + 6'd2;
      6'd7:  begin m_a = opnd; next_pc = m_pc + 6'd2; end
      6'd8:  m_a = m_a + 6'd1;
      6'd9:  m_a = ~m_a;
      6'd16: exec_out = {2'b11, m_a};
      default: ;
    endcase
    exp_q.push_back({2'b00, m_pc});
    exp_q.push_back(exec_out);
    m_pc = next_pc;
  endtask

  // Compare process: checks io_out against the model on every cycle after reset.
  always @(negedge clk) begin
    logic [7:0] want;
    if (rst_seen) begin
      m_a = 6'd0; m_b = 6'd1; m_c = 6'd0; m_pc = 6'd0;
      exp_q.delete();
      m_valid = 1'b1;
    end
    if (m_valid) begin
      if (exp_q.size() == 0) iss_step();
      want = exp_q.pop_front();
      check("model_io_out", io_out, want);
    end
    if (io_out[7] === 1'b1) out_pulses++;
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with hand-computed expectations.
  // k counts falling edges since the reset edge. Instruction i has its fetch
  // cycle at k = 2i and its execute cycle at k = 2i + 1.
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 6'd0;
    mem[0] = 6'd1;  mem[1] = 6'd2;  mem[2] = 6'd16; mem[3] = 6'd6;
    mem[4] = 6'd0;  mem[5] = 6'd7;  mem[6] = 6'd63; mem[7] = 6'd4;
    mem[8] = 6'd1;  mem[9] = 6'd3;  mem[10] = 6'd9; mem[11] = 6'd8;
    mem[12] = 6'd5; mem[13] = 6'd7;
  end

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      #1;
      case (k)
        0:  check("reset_fetch_pc0", io_out, 8'h00);
        1:  check("first_exec_phase", io_out, 8'h41);
        2:  check("second_fetch_pc1", io_out, 8'h02 - 8'h01);
        5:  check("out_strobe_a1", io_out, 8'hC1);
        7:  check("jz_exec_operand_addr", io_out, 8'h44);
        8:  check("jz_not_taken_pc5", io_out, 8'h05);
        10: begin
          check("ldi_a63", {2'b00, dut.reg_a}, 8'd63);
          check("fetch_pc7", io_out, 8'h07);
        end
        12: check("c_gets_63", {2'b00, dut.reg_c}, 8'd63);
        14: check("wrap_add_a0", {2'b00, dut.reg_a}, 8'd0);
        22: begin
          check("jmp_back_pc7", io_out, 8'h07);
          check("a_after_inc", {2'b00, dut.reg_a}, 8'd1);
        end
        24: check("loop_c1", {2'b00, dut.reg_c}, 8'd1);
        30: check("loop_a62", {2'b00, dut.reg_a}, 8'd62);
        32: begin
          check("loop_a63", {2'b00, dut.reg_a}, 8'd63);
          check("b_stays_1", {2'b00, dut.reg_b}, 8'd1);
        end
        40: check("single_out_pulse", 8'(out_pulses), 8'd1);
        45: rst = 1'b1;  // abort the instruction that is executing now
        46: begin
          check("midreset_io_out", io_out, 8'h00);
          check("midreset_pc", {2'b00, dut.pc}, 8'd0);
          check("midreset_a", {2'b00, dut.reg_a}, 8'd0);
          check("midreset_b", {2'b00, dut.reg_b}, 8'd1);
          check("midreset_c", {2'b00, dut.reg_c}, 8'd0);
          check("midreset_phase", {7'd0, dut.micro_pc}, 8'd0);
          rst = 1'b0;
        end
        47: check("restart_exec", io_out, 8'h41);
        59: check("replay_out_pulse", 8'(out_pulses), 8'd2);
        default: ;
      endcase
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
